// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 8-slot TDM receive demultiplexer.
package tdm_demux_pkg;
    localparam int NUM_SLOTS     = 8;
    localparam int ERR_CNT_W_DEF = 8;

    typedef logic [2:0] slot_t;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);
endpackage

// File: rtl/tdm_demux_1to8_slot_counter.sv
// Slot position counter: clear, load-to-1 on frame start, increment wrapping after slot 7.
module tdm_slot_counter
    import tdm_demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_clr,
    input  logic  i_en,
    input  logic  i_load1,
    input  logic  i_inc,
    output slot_t o_cnt
);

    slot_t r_cnt;

    // Slot counter register; load1 wins over inc, everything holds when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 3'd0;
        end else if (i_clr) begin
            r_cnt <= 3'd0;
        end else if (i_en && i_load1) begin
            r_cnt <= 3'd1;
        end else if (i_en && i_inc) begin
            r_cnt <= (r_cnt == LAST_SLOT) ? 3'd0 : r_cnt + 3'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/tdm_demux_1to8.sv
// Serial-to-parallel TDM receiver: frame sync alignment, 8-bit channel reconstruction, sync error tracking.
// Optional TDM_SEL_OUT_EN exposes the slot counter as s0,s1,s2 for the upstream MUX select.
module tdm_demux_1to8
    import tdm_demux_pkg::*;
#(
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 din,
    input  logic                 din_en,
    input  logic                 sync,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 d,
    output logic                 e,
    output logic                 f,
    output logic                 g,
    output logic                 h,
    output logic                 frame_valid,
    output logic                 locked,
    output logic                 sync_err,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef TDM_SEL_OUT_EN
    ,
    output logic                 s0,
    output logic                 s1,
    output logic                 s2
`endif
);

    state_t               r_state;
    state_t               w_state_nxt;
    slot_t                w_slot;
    logic                 w_load1;
    logic                 w_inc;
    logic                 w_frame_done;
    logic                 w_err;
    logic [7:0]           w_stage_nxt;
    logic [7:0]           r_stage;
    logic [7:0]           r_chan;
    logic                 r_frame_valid;
    logic                 r_locked;
    logic                 r_sync_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (clr),
        .i_en    (din_en),
        .i_load1 (w_load1),
        .i_inc   (w_inc),
        .o_cnt   (w_slot)
    );

    // Next-state, staging update and event decode; only qualified slots advance anything.
    always_comb begin
        w_state_nxt  = r_state;
        w_load1      = 1'b0;
        w_inc        = 1'b0;
        w_frame_done = 1'b0;
        w_err        = 1'b0;
        w_stage_nxt  = r_stage;
        if (din_en) begin
            case (r_state)
                HUNT: begin
                    if (sync) begin
                        w_stage_nxt[0] = din;
                        w_load1        = 1'b1;
                        w_state_nxt    = LOCKED;
                    end else begin
                        w_state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A sync anywhere but slot 0 abandons the partial frame and restarts.
                        w_stage_nxt[0] = din;
                        w_load1        = 1'b1;
                        w_err          = (w_slot != 3'd0);
                    end else if (w_slot == 3'd0) begin
                        w_err       = 1'b1;
                        w_state_nxt = HUNT;
                    end else begin
                        w_stage_nxt[w_slot] = din;
                        w_inc               = 1'b1;
                        w_frame_done        = (w_slot == LAST_SLOT);
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
        end else if (clr) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Staging, channel outputs, status pulses and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage       <= 8'h00;
            r_chan        <= 8'h00;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_err_cnt     <= {ERR_CNT_W{1'b0}};
        end else if (clr) begin
            r_stage       <= 8'h00;
            r_chan        <= 8'h00;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_err_cnt     <= {ERR_CNT_W{1'b0}};
        end else begin
            r_stage       <= w_stage_nxt;
            r_frame_valid <= w_frame_done;
            r_locked      <= (w_state_nxt == LOCKED);
            r_sync_err    <= w_err;
            if (w_frame_done) begin
                r_chan <= w_stage_nxt;
            end else begin
                r_chan <= r_chan;
            end
            if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end
    end

    assign a           = r_chan[0];
    assign b           = r_chan[1];
    assign c           = r_chan[2];
    assign d           = r_chan[3];
    assign e           = r_chan[4];
    assign f           = r_chan[5];
    assign g           = r_chan[6];
    assign h           = r_chan[7];
    assign frame_valid = r_frame_valid;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;
    assign err_cnt     = r_err_cnt;

`ifdef TDM_SEL_OUT_EN
    assign {s0, s1, s2} = w_slot;
`endif

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Directed self-checking bench for tdm_demux_1to8 (channel vector shown as {a..h}, a = MSB).
module tb_tdm_demux_1to8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       din = 1'b0;
    logic       din_en = 1'b0;
    logic       sync = 1'b0;
    logic       a, b, c, d, e, f, g, h;
    logic       frame_valid, locked, sync_err;
    logic [7:0] err_cnt;
    logic [7:0] chan;
    logic [2:0] sel;
    int         n_cmp = 0;
    int         n_err = 0;

    tdm_demux_1to8 #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .din_en(din_en), .sync(sync),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err),
        .err_cnt(err_cnt)
`ifdef TDM_SEL_OUT_EN
        , .s0(sel[2]), .s1(sel[1]), .s2(sel[0])
`endif
    );

`ifndef TDM_SEL_OUT_EN
    assign sel = 3'd0;
`endif

    assign chan = {a, b, c, d, e, f, g, h};

    always #5 clk = ~clk;

    task automatic step(input logic en, input logic s, input logic dbit);
        din_en = en;
        sync   = s;
        din    = dbit;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({chan, frame_valid, locked, sync_err, err_cnt} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_async: got %h expected 0", {chan, frame_valid, locked, sync_err, err_cnt});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({chan, frame_valid, locked, sync_err, err_cnt, sel} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_state: got %h expected 0", {chan, frame_valid, locked, sync_err, err_cnt, sel});
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] pat;
        int         fv_cnt;
        pat    = 8'b1011_0010;
        fv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), pat[7-i]);
            fv_cnt += int'(frame_valid);
        end
        n_cmp++;
        if (chan !== 8'hB2) begin
            n_err++;
            $display("FAIL single_chan: got %h expected %h", chan, 8'hB2);
        end
        n_cmp++;
        if (frame_valid !== 1'b1 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL single_fv_locked: got %b%b expected 11", frame_valid, locked);
        end
        step(1'b0, 1'b0, 1'b0);
        fv_cnt += int'(frame_valid);
        n_cmp++;
        if (fv_cnt !== 1) begin
            n_err++;
            $display("FAIL single_fv_count: got %0d expected 1", fv_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int fv_cnt;
        fv_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                step(1'b1, (i == 0), (k == 0));
                fv_cnt += int'(frame_valid);
`ifdef TDM_SEL_OUT_EN
                n_cmp++;
                if (sel !== 3'((i + 1) % 8)) begin
                    n_err++;
                    $display("FAIL b2b_sel: got %0d expected %0d", sel, (i + 1) % 8);
                end
`endif
            end
            n_cmp++;
            if (frame_valid !== 1'b1 || chan !== ((k == 0) ? 8'hFF : 8'h00)) begin
                n_err++;
                $display("FAIL b2b_frame%0d: got fv=%b chan=%h expected fv=1 chan=%h",
                         k, frame_valid, chan, (k == 0) ? 8'hFF : 8'h00);
            end
        end
        n_cmp++;
        if (fv_cnt !== 2) begin
            n_err++;
            $display("FAIL b2b_fv_count: got %0d expected 2", fv_cnt);
        end
    endtask

    task automatic test_early_sync();
        logic [7:0] pat;
        pat = 8'b1100_1101;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, pat[7]);
        n_cmp++;
        if ({sync_err, err_cnt, chan, frame_valid} !== {1'b1, 8'd1, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL early_err: got serr=%b cnt=%0d chan=%h fv=%b expected 1/1/00/0",
                     sync_err, err_cnt, chan, frame_valid);
        end
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 1'b0, pat[7-i]);
            if (i == 1) begin
                n_cmp++;
                if (sync_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL early_err_pulse: got %b expected 0", sync_err);
                end
            end
            n_cmp++;
            if (frame_valid !== (i == 7)) begin
                n_err++;
                $display("FAIL early_fv_slot%0d: got %b expected %b", i, frame_valid, (i == 7));
            end
        end
        n_cmp++;
        if (chan !== 8'hCD) begin
            n_err++;
            $display("FAIL early_chan: got %h expected %h", chan, 8'hCD);
        end
    endtask

    task automatic test_missing_sync();
        logic [7:0] pat;
        int         fv_cnt;
        pat    = 8'h3C;
        fv_cnt = 0;
        step(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({sync_err, err_cnt, locked} !== {1'b1, 8'd2, 1'b0}) begin
            n_err++;
            $display("FAIL missing_err: got serr=%b cnt=%0d locked=%b expected 1/2/0", sync_err, err_cnt, locked);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1);
            fv_cnt += int'(frame_valid);
        end
        n_cmp++;
        if (fv_cnt !== 0 || chan !== 8'hCD || locked !== 1'b0 || err_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL missing_hunt: got fv=%0d chan=%h locked=%b cnt=%0d expected 0/CD/0/2",
                     fv_cnt, chan, locked, err_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), pat[7-i]);
        end
        n_cmp++;
        if ({frame_valid, locked, chan} !== {1'b1, 1'b1, 8'h3C}) begin
            n_err++;
            $display("FAIL missing_relock: got fv=%b locked=%b chan=%h expected 1/1/3C", frame_valid, locked, chan);
        end
    endtask

    task automatic test_gaps_clr_sat();
        logic [7:0] pat;
        int         fv_cnt;
        pat    = 8'h96;
        fv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, ~pat[7-i]);
            fv_cnt += int'(frame_valid);
            step(1'b1, (i == 0), pat[7-i]);
            if (i < 7) begin
                fv_cnt += int'(frame_valid);
            end
        end
        n_cmp++;
        if ({frame_valid, chan, err_cnt} !== {1'b1, 8'h96, 8'd2} || fv_cnt !== 0) begin
            n_err++;
            $display("FAIL gaps_frame: got fv=%b early_fv=%0d chan=%h cnt=%0d expected 1/0/96/2",
                     frame_valid, fv_cnt, chan, err_cnt);
        end
        step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({frame_valid, sync_err, chan} !== {1'b0, 1'b0, 8'h96}) begin
            n_err++;
            $display("FAIL gaps_hold: got fv=%b serr=%b chan=%h expected 0/0/96", frame_valid, sync_err, chan);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i == 0), 1'b1);
        end
        clr = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        clr = 1'b0;
        n_cmp++;
        if ({chan, frame_valid, locked, sync_err, err_cnt, sel} !== 22'd0) begin
            n_err++;
            $display("FAIL clr_zero: got %h expected 0", {chan, frame_valid, locked, sync_err, err_cnt, sel});
        end
        step(1'b1, 1'b1, 1'b0);
        for (int n = 1; n <= 300; n++) begin
            step(1'b1, 1'b1, 1'b0);
            if (n == 1 || n == 254 || n == 255 || n == 300) begin
                n_cmp++;
                if (sync_err !== 1'b1 || err_cnt !== ((n > 255) ? 8'd255 : 8'(n))) begin
                    n_err++;
                    $display("FAIL sat_err%0d: got serr=%b cnt=%0d expected 1/%0d",
                             n, sync_err, err_cnt, (n > 255) ? 255 : n);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] pat;
        pat = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), pat[7-i]);
        end
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (chan !== 8'h5A || locked !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre: got chan=%h locked=%b expected 5A/1", chan, locked);
        end
`ifdef TDM_SEL_OUT_EN
        n_cmp++;
        if (sel !== 3'd3) begin
            n_err++;
            $display("FAIL rst_pre_sel: got %0d expected 3", sel);
        end
`endif
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({chan, frame_valid, locked, sync_err, err_cnt, sel} !== 22'd0) begin
            n_err++;
            $display("FAIL rst_async_mid: got %h expected 0", {chan, frame_valid, locked, sync_err, err_cnt, sel});
        end
        #2;
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({locked, frame_valid, sync_err} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_hunt: got %b expected 000", {locked, frame_valid, sync_err});
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0), pat[7-i]);
        end
        n_cmp++;
        if ({frame_valid, locked, chan, err_cnt} !== {1'b1, 1'b1, 8'h5A, 8'd0}) begin
            n_err++;
            $display("FAIL rst_recover: got fv=%b locked=%b chan=%h cnt=%0d expected 1/1/5A/0",
                     frame_valid, locked, chan, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_early_sync();
        test_missing_sync();
        test_gaps_clr_sat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
